// File: rtl/conf_control_pkg.sv
// Shared definitions for the UART configuration controller: default command
// codes, FSM state encodings, the byte type and the addressed-range check.
package conf_control_pkg;

  typedef logic [7:0] byte_t;

  // Default command codes; the top level exposes them as overridable parameters.
  localparam byte_t CMD_WR_DEF  = 8'h0F;
  localparam byte_t CMD_RD_DEF  = 8'hF0;
  localparam byte_t CMD_WRA_DEF = 8'h1F;
  localparam byte_t CMD_RDA_DEF = 8'hF1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_GET_ADDR = 3'd1;
  localparam state_t ST_GET_LEN  = 3'd2;
  localparam state_t ST_WR_DATA  = 3'd3;
  localparam state_t ST_TX_REQ   = 3'd4;
  localparam state_t ST_TX_WAIT  = 3'd5;

  // True when [addr, addr+len) is a non-empty window inside the register file.
  // The sum is formed in 9 bits so addr+len cannot wrap.
  function automatic logic range_ok(input byte_t addr, input byte_t len,
                                    input int unsigned nbytes);
    logic [8:0] sum;
    sum = {1'b0, addr} + {1'b0, len};
    return (len != 8'd0) && (32'(addr) < nbytes) && (32'(sum) <= nbytes);
  endfunction

endpackage

// File: rtl/conf_regfile.sv
// Shadow and committed configuration byte arrays.
//   load_shadow : copy committed bytes into the shadow
//   wr_en/wr_addr/wr_data : write one shadow byte
//   commit      : copy shadow to committed; a byte written in the same cycle
//                 lands in the committed copy directly
//   rd_addr/rd_data_c : combinational read of the committed bytes
//   regs        : committed bytes, byte k = regs[8k+7:8k]
module conf_regfile
  import conf_control_pkg::*;
#(
  parameter int unsigned NBYTES = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_shadow,
  input  logic                  wr_en,
  input  byte_t                 wr_addr,
  input  byte_t                 wr_data,
  input  logic                  commit,
  input  byte_t                 rd_addr,
  output byte_t                 rd_data_c,
  output logic [8*NBYTES-1:0]   regs
);

  byte_t shadow [NBYTES];

  // Shadow update and atomic commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '{default: '0};
      regs   <= '0;
    end else begin
      for (int k = 0; k < int'(NBYTES); k++) begin
        if (load_shadow) begin
          shadow[k] <= regs[8*k +: 8];
        end else if (wr_en && (wr_addr == 8'(k))) begin
          shadow[k] <= wr_data;
        end
        if (commit) begin
          regs[8*k +: 8] <= (wr_en && (wr_addr == 8'(k))) ? wr_data : shadow[k];
        end
      end
    end
  end

  // Read mux over committed bytes; out-of-range addresses read zero.
  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < int'(NBYTES); k++) begin
      if (rd_addr == 8'(k)) begin
        rd_data_c = regs[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/conf_control_param.sv
// UART-side configuration controller. Parses full/addressed write and read
// frames from the receive byte stream, commits writes atomically, aborts
// stalled or malformed frames, and returns register bytes via the TX handshake.
//   clk, rst        : clock, asynchronous active-high reset
//   rxdw, rxrdy     : received byte and its one-cycle strobe
//   txbusy          : UART transmitter busy
//   txdw, txena     : byte to transmit and one-cycle transmit request
//   regs            : committed configuration
//   cfg_upd         : one-cycle pulse after each commit
//   frame_err       : one-cycle pulse after each frame abort
//   sleds           : {sticky error flag, control byte NBYTES-1}
module conf_control_param
  import conf_control_pkg::*;
#(
  parameter int unsigned NBYTES       = 11,
  parameter int unsigned TIMEOUT_CLKS = 50000,
  parameter byte_t       CMD_WR       = CMD_WR_DEF,
  parameter byte_t       CMD_RD       = CMD_RD_DEF,
  parameter byte_t       CMD_WRA      = CMD_WRA_DEF,
  parameter byte_t       CMD_RDA      = CMD_RDA_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rxdw,
  input  logic                rxrdy,
  input  logic                txbusy,
  output logic [7:0]          txdw,
  output logic                txena,
  output logic [8*NBYTES-1:0] regs,
  output logic                cfg_upd,
  output logic                frame_err,
  output logic [8:0]          sleds
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);

  state_t           state_q, state_d;
  byte_t            ptr_q, ptr_d;
  byte_t            cnt_q, cnt_d;
  logic             mode_wr_q, mode_wr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  byte_t            txdw_q, txdw_d;
  logic             txena_q, txena_d;
  logic             cfg_upd_q, cfg_upd_d;
  logic             frame_err_q, frame_err_d;
  logic             err_q, err_d;

  logic             rf_load, rf_wr, rf_commit;
  byte_t            rf_rd_c;
  logic             tmo_expired_c;

  conf_regfile #(.NBYTES(NBYTES)) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .load_shadow (rf_load),
    .wr_en       (rf_wr),
    .wr_addr     (ptr_q),
    .wr_data     (rxdw),
    .commit      (rf_commit),
    .rd_addr     (ptr_q),
    .rd_data_c   (rf_rd_c),
    .regs        (regs)
  );

  // The counter has seen TIMEOUT_CLKS-1 idle cycles; this idle cycle is the last.
  assign tmo_expired_c = (tmo_q >= TMO_W'(TIMEOUT_CLKS - 1));

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mode_wr_q   <= 1'b0;
      tmo_q       <= '0;
      txdw_q      <= '0;
      txena_q     <= 1'b0;
      cfg_upd_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      mode_wr_q   <= mode_wr_d;
      tmo_q       <= tmo_d;
      txdw_q      <= txdw_d;
      txena_q     <= txena_d;
      cfg_upd_q   <= cfg_upd_d;
      frame_err_q <= frame_err_d;
      err_q       <= err_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    mode_wr_d   = mode_wr_q;
    tmo_d       = tmo_q;
    txdw_d      = txdw_q;
    txena_d     = 1'b0;
    cfg_upd_d   = 1'b0;
    frame_err_d = 1'b0;
    err_d       = err_q;
    rf_load     = 1'b0;
    rf_wr       = 1'b0;
    rf_commit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rxrdy) begin
          tmo_d = '0;
          if (rxdw == CMD_WR) begin
            rf_load = 1'b1;
            ptr_d   = '0;
            cnt_d   = 8'(NBYTES);
            state_d = ST_WR_DATA;
          end else if (rxdw == CMD_WRA) begin
            rf_load   = 1'b1;
            mode_wr_d = 1'b1;
            state_d   = ST_GET_ADDR;
          end else if (rxdw == CMD_RD) begin
            ptr_d   = '0;
            cnt_d   = 8'(NBYTES);
            state_d = ST_TX_REQ;
          end else if (rxdw == CMD_RDA) begin
            mode_wr_d = 1'b0;
            state_d   = ST_GET_ADDR;
          end
        end
      end

      ST_GET_ADDR: begin
        if (rxrdy) begin
          tmo_d   = '0;
          ptr_d   = rxdw;
          state_d = ST_GET_LEN;
        end else if (tmo_expired_c) begin
          tmo_d       = '0;
          frame_err_d = 1'b1;
          err_d       = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_GET_LEN: begin
        if (rxrdy) begin
          tmo_d = '0;
          cnt_d = rxdw;
          if (!range_ok(ptr_q, rxdw, NBYTES)) begin
            frame_err_d = 1'b1;
            err_d       = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = mode_wr_q ? ST_WR_DATA : ST_TX_REQ;
          end
        end else if (tmo_expired_c) begin
          tmo_d       = '0;
          frame_err_d = 1'b1;
          err_d       = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_WR_DATA: begin
        if (rxrdy) begin
          tmo_d = '0;
          rf_wr = 1'b1;
          ptr_d = ptr_q + 8'd1;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            rf_commit = 1'b1;
            cfg_upd_d = 1'b1;
            err_d     = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (tmo_expired_c) begin
          tmo_d       = '0;
          frame_err_d = 1'b1;
          err_d       = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_TX_REQ: begin
        if (!txbusy) begin
          txdw_d  = rf_rd_c;
          txena_d = 1'b1;
          state_d = ST_TX_WAIT;
        end
      end

      ST_TX_WAIT: begin
        // txena_q is high exactly on the first TX_WAIT cycle, when the
        // transmitter has not yet raised txbusy.
        if (!txena_q && !txbusy) begin
          ptr_d   = ptr_q + 8'd1;
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? ST_IDLE : ST_TX_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign txdw      = txdw_q;
  assign txena     = txena_q;
  assign cfg_upd   = cfg_upd_q;
  assign frame_err = frame_err_q;
  assign sleds     = {err_q, regs[8*(NBYTES-1) +: 8]};

endmodule

// File: tb/tb_conf_control_param.sv
// Self-checking bench for conf_control_param: directed frames, a byte-array
// model of the committed registers, an expected-TX queue and a busy model.
module tb_conf_control_param;

  localparam int NB  = 11;
  localparam int TMO = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      rxdw;
  logic            rxrdy;
  logic            txbusy = 1'b0;
  logic [7:0]      txdw;
  logic            txena;
  logic [8*NB-1:0] regs;
  logic            cfg_upd;
  logic            frame_err;
  logic [8:0]      sleds;

  conf_control_param #(.NBYTES(NB), .TIMEOUT_CLKS(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxdw      (rxdw),
    .rxrdy     (rxrdy),
    .txbusy    (txbusy),
    .txdw      (txdw),
    .txena     (txena),
    .regs      (regs),
    .cfg_upd   (cfg_upd),
    .frame_err (frame_err),
    .sleds     (sleds)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_regs [NB];
  logic       exp_err;
  logic       model_valid = 1'b0;
  logic [7:0] exp_tx [$];
  int         cnt_upd = 0;
  int         cnt_err = 0;
  int         busy_cnt = 0;
  logic       prev_txena = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [8*NB-1:0] model_vec();
    logic [8*NB-1:0] v;
    for (int k = 0; k < NB; k++) v[8*k +: 8] = exp_regs[k];
    return v;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NB; k++) exp_regs[k] = 8'h00;
    exp_err = 1'b0;
  endfunction

  // Compare process: register/flag model, TX stream, pulse counting, busy model.
  always @(negedge clk) begin
    if (!rst) begin
      if (model_valid) begin
        check("regs", regs, model_vec());
        check("sleds", sleds, {exp_err, exp_regs[NB-1]});
      end
      if (txena) begin
        check("txena_width", prev_txena, 1'b0);
        check("txena_vs_busy", txbusy, 1'b0);
        if (exp_tx.size() == 0) begin
          check("txena_unexpected", 1'b1, 1'b0);
        end else begin
          check("txdw", txdw, exp_tx.pop_front());
        end
      end
      if (cfg_upd)   cnt_upd++;
      if (frame_err) cnt_err++;
    end
    prev_txena = txena;
    // Transmitter reacts to the request and stays busy for 10 clocks.
    if (txena && busy_cnt == 0) busy_cnt = 10;
    else if (busy_cnt > 0)      busy_cnt--;
    txbusy = (busy_cnt > 0);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxdw  = b;
    rxrdy = 1'b1;
    @(negedge clk);
    rxrdy = 1'b0;
  endtask

  // Sends a frame; the model is masked from the last byte until it settles.
  task automatic run_frame(input logic [7:0] fr [$]);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == fr.size() - 1) model_valid = 1'b0;
      send_byte(fr[i]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_pulses(input string nm, input int c0, input int e0,
                              input int du, input int de);
    check({nm, "_cfg_upd"}, 128'(cnt_upd - c0), 128'(du));
    check({nm, "_frame_err"}, 128'(cnt_err - e0), 128'(de));
  endtask

  task automatic full_write(input string nm, input logic [7:0] base);
    logic [7:0] fr [$];
    int c0, e0;
    c0 = cnt_upd; e0 = cnt_err;
    fr.push_back(8'h0F);
    for (int i = 0; i < NB; i++) fr.push_back(base + 8'(i));
    run_frame(fr);
    for (int i = 0; i < NB; i++) exp_regs[i] = base + 8'(i);
    exp_err = 1'b0;
    model_valid = 1'b1;
    check_pulses(nm, c0, e0, 1, 0);
  endtask

  task automatic addr_write(input string nm, input int addr, input logic [7:0] d [$]);
    logic [7:0] fr [$];
    int c0, e0;
    c0 = cnt_upd; e0 = cnt_err;
    fr = {8'h1F, 8'(addr), 8'(d.size())};
    for (int i = 0; i < d.size(); i++) fr.push_back(d[i]);
    run_frame(fr);
    for (int i = 0; i < d.size(); i++) exp_regs[addr + i] = d[i];
    exp_err = 1'b0;
    model_valid = 1'b1;
    check_pulses(nm, c0, e0, 1, 0);
  endtask

  task automatic bad_frame(input string nm, input logic [7:0] fr [$]);
    int c0, e0;
    c0 = cnt_upd; e0 = cnt_err;
    run_frame(fr);
    exp_err = 1'b1;
    model_valid = 1'b1;
    check_pulses(nm, c0, e0, 0, 1);
  endtask

  task automatic do_read(input string nm, input logic [7:0] hdr [$],
                         input int addr, input int len, input bit inject);
    int c0, e0;
    c0 = cnt_upd; e0 = cnt_err;
    for (int i = 0; i < len; i++) exp_tx.push_back(exp_regs[addr + i]);
    for (int i = 0; i < hdr.size(); i++) send_byte(hdr[i]);
    if (inject) begin
      repeat (4) @(negedge clk);
      send_byte(8'h0F);
    end
    for (int i = 0; i < 3000 && exp_tx.size() != 0; i++) @(negedge clk);
    check({nm, "_tx_drained"}, 128'(exp_tx.size()), 128'(0));
    exp_tx.delete();
    repeat (20) @(negedge clk);
    check_pulses(nm, c0, e0, 0, 0);
  endtask

  initial begin
    int c0, e0;
    rst = 1'b1; rxdw = 8'h00; rxrdy = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_regs", regs, 88'h0);
    check("rst_sleds", sleds, 9'h000);
    check("rst_txena", txena, 1'b0);
    check("rst_txdw", txdw, 8'h00);
    check("rst_cfg_upd", cfg_upd, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    model_valid = 1'b1;

    // Full write 01..0B, then full read.
    full_write("wr_full", 8'h01);
    check("wr_full_lit", regs, 88'h0B0A09080706050403020_1);
    check("wr_full_sleds", sleds, 9'h00B);
    do_read("rd_full", '{8'hF0}, 0, NB, 1'b0);

    // Unknown byte in idle is ignored without error.
    c0 = cnt_upd; e0 = cnt_err;
    send_byte(8'h55);
    repeat (3) @(negedge clk);
    check_pulses("ignored", c0, e0, 0, 0);

    // Addressed write and read; a byte arriving mid-read is dropped.
    addr_write("wra", 3, '{8'hAA, 8'hBB});
    check("wra_lit", regs, 88'h0B0A0908070_6BBAA030201);
    do_read("rda", '{8'hF1, 8'h03, 8'h02}, 3, 2, 1'b1);

    // Boundary: last byte only (10+1 == 11).
    addr_write("wra_top", 10, '{8'h5A});
    check("wra_top_sleds", sleds, 9'h05A);

    // Inter-byte timeout after 5 of 11 data bytes.
    c0 = cnt_upd; e0 = cnt_err;
    send_byte(8'h0F);
    for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i));
    repeat (TMO / 2) @(negedge clk);
    check("tmo_not_early", 128'(cnt_err - e0), 128'(0));
    model_valid = 1'b0;
    for (int i = 0; i < TMO + 100 && cnt_err == e0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    exp_err = 1'b1;
    model_valid = 1'b1;
    check_pulses("tmo", c0, e0, 0, 1);
    check("tmo_sticky", sleds[8], 1'b1);
    full_write("wr_clear", 8'h10);
    check("wr_clear_sleds", sleds, 9'h01A);

    // Range violations abort immediately without commit.
    bad_frame("rng_over", '{8'h1F, 8'h0A, 8'h02});
    bad_frame("rng_zero", '{8'h1F, 8'h00, 8'h00});
    bad_frame("rng_addr", '{8'h1F, 8'h0B, 8'h01});
    check("rng_sticky", sleds[8], 1'b1);

    // Reset mid-frame discards the frame.
    send_byte(8'h0F);
    for (int i = 0; i < 6; i++) send_byte(8'h70 + 8'(i));
    model_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_clear();
    check("midrst_regs", regs, 88'h0);
    check("midrst_txena", txena, 1'b0);
    check("midrst_sleds", sleds, 9'h000);
    rst = 1'b0;
    model_valid = 1'b1;
    full_write("wr_after_rst", 8'h21);
    check("wr_after_rst_lit", regs, 88'h2B2A29282726252423222_1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
